// File: rtl/accumulator_update_dispatcher_if.sv
// Request/issue bundle shared by the move decoder, the update dispatcher and the feature accumulator.
// The master modport is the dispatcher's view; the slave modport is the view of the decoder and accumulator.
interface accumulator_update_dispatcher_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_row;
  logic       in_add;
  logic       in_player;
  logic [6:0] acc_row;
  logic       acc_add;
  logic       acc_player;
  logic       acc_trigger;
  logic       acc_finish;

  modport master (
    input  in_valid, in_row, in_add, in_player, acc_finish,
    output in_ready, acc_row, acc_add, acc_player, acc_trigger
  );

  modport slave (
    output in_valid, in_row, in_add, in_player, acc_finish,
    input  in_ready, acc_row, acc_add, acc_player, acc_trigger
  );
endinterface

// File: rtl/accumulator_update_dispatcher.sv
// Queues feature-row update requests and issues them one at a time to the feature accumulator,
// using its trigger/finish handshake, and pulses batch_done once every queued update has been applied.
module accumulator_update_dispatcher #(
  parameter int INPUT_FEATURES = 121,
  parameter int FIFO_DEPTH     = 32,
  parameter int INIT_DELAY     = 8,
  parameter int TIMEOUT        = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  accumulator_update_dispatcher_if.master bus,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          batch_done,
  output logic                          err_range,
  output logic                          err_timeout,
  input  logic                          clear_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(INIT_DELAY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] ROW_LIMIT = 8'(INPUT_FEATURES);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_GAP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] init_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          push;
  logic          store;
  logic          pop;
  logic          tmo_hit;
  logic          fifo_empty;
  logic          fifo_full;

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign level        = wr_ptr - rd_ptr;
  assign fifo_empty   = (level == '0);
  assign fifo_full    = (level == PW'(FIFO_DEPTH));
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full;
  assign store        = push && ({1'b0, bus.in_row} < ROW_LIMIT);
  assign busy         = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_INIT: begin
        if (init_cnt == IW'(INIT_DELAY - 1)) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.acc_finish) begin
          state_nxt = S_GAP;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (store) begin
      mem[wr_ptr[AW-1:0]] <= {bus.in_row, bus.in_add, bus.in_player};
    end
  end

  // acc_* only load on the pop edge, so they stay stable for the whole update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      init_cnt        <= '0;
      tmo_cnt         <= '0;
      bus.acc_row     <= '0;
      bus.acc_add     <= 1'b0;
      bus.acc_player  <= 1'b0;
      bus.acc_trigger <= 1'b0;
      batch_done      <= 1'b0;
      err_range       <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        {bus.acc_row, bus.acc_add, bus.acc_player} <= mem[rd_ptr[AW-1:0]];
        tmo_cnt <= '0;
      end else if (state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (state == S_INIT) init_cnt <= init_cnt + IW'(1);
      bus.acc_trigger <= pop;
      batch_done      <= (state == S_GAP) && fifo_empty && !push;
      if (clear_err) begin
        err_range   <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (push && !store) err_range <= 1'b1;
        if (tmo_hit) err_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_accumulator_update_dispatcher.sv
// Scoreboard bench for accumulator_update_dispatcher: directed scenarios plus a randomised phase,
// with a behavioural accumulator that answers each trigger with a finish pulse.
module tb_accumulator_update_dispatcher;
  localparam int INPUT_FEATURES = 121;
  localparam int FIFO_DEPTH     = 32;
  localparam int INIT_DELAY     = 8;
  localparam int TIMEOUT        = 64;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic                        batch_done;
  logic                        err_range;
  logic                        err_timeout;
  logic                        clear_err;

  accumulator_update_dispatcher_if bus ();

  accumulator_update_dispatcher #(
    .INPUT_FEATURES(INPUT_FEATURES),
    .FIFO_DEPTH(FIFO_DEPTH),
    .INIT_DELAY(INIT_DELAY),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy),
    .level(level),
    .batch_done(batch_done),
    .err_range(err_range),
    .err_timeout(err_timeout),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc;
  logic [8:0] exp_q[$];
  logic [8:0] held;
  bit         finish_en;
  bit         rand_lat;
  int         fin_lat;
  int         cur_lat;
  bit         pend;
  int         pend_cnt;
  bit         prev_trig;
  bit         prev_tmo;
  bit         fin_gap_chk;
  int         trig_cyc;
  int         fin_cyc;
  int         batch_cnt = 0;
  bit         model_err_range;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Accumulator model and monitor: pops the expected request on every trigger and answers with finish.
  always @(negedge clk) begin
    bus.acc_finish = 1'b0;
    if (!rst_n) begin
      pend        = 1'b0;
      prev_trig   = 1'b0;
      prev_tmo    = 1'b0;
      fin_gap_chk = 1'b0;
    end else begin
      if (err_timeout && !prev_tmo) pend = 1'b0;
      prev_tmo = err_timeout;
      if (bus.acc_trigger) begin
        checkOutput("trigger_width", {31'd0, prev_trig}, 32'd0);
        if (fin_gap_chk) checkOutput("finish_to_trigger", cyc - fin_cyc, 32'd3);
        fin_gap_chk = 1'b0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_trigger actual=row %0d required=no trigger", bus.acc_row);
          held = {bus.acc_row, bus.acc_add, bus.acc_player};
        end else begin
          held = exp_q.pop_front();
          checkOutput("acc_fields", {23'd0, bus.acc_row, bus.acc_add, bus.acc_player}, {23'd0, held});
        end
        pend     = 1'b1;
        pend_cnt = 0;
        trig_cyc = cyc;
        cur_lat  = rand_lat ? int'($urandom_range(1, 4)) : fin_lat;
      end else if (pend) begin
        checkOutput("acc_stable", {23'd0, bus.acc_row, bus.acc_add, bus.acc_player}, {23'd0, held});
        if (finish_en) begin
          pend_cnt++;
          if (pend_cnt >= cur_lat) begin
            bus.acc_finish = 1'b1;
            pend           = 1'b0;
            fin_cyc        = cyc;
            fin_gap_chk    = (exp_q.size() != 0);
          end
        end
      end
      prev_trig = bus.acc_trigger;
      if (batch_done) begin
        batch_cnt++;
        checkOutput("batch_done_latency", cyc - fin_cyc, 32'd2);
      end
    end
  end

  task automatic applyStimulus(input logic [6:0] row, input logic add, input logic player,
                               output bit accepted);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_row    = row;
    bus.in_add    = add;
    bus.in_player = player;
    accepted      = bus.in_ready;
    if (accepted) begin
      if (int'(row) < INPUT_FEATURES) exp_q.push_back({row, add, player});
      else model_err_range = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || pend || busy) && n < bound);
    if (n >= bound) begin
      total++;
      bad++;
      $display("[TB] FAIL %s idle_wait actual=level %0d queued %0d busy %0d required=idle",
               name, level, exp_q.size(), busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    clear_err    = 1'b0;
    exp_q.delete();
    model_err_range = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int n;
    int b0;
    rst_n         = 1'b0;
    clear_err     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.in_add    = 1'b0;
    bus.in_player = 1'b0;
    finish_en     = 1'b1;
    rand_lat      = 1'b0;
    fin_lat       = 3;

    // Scenario 1: reset values, single request behind the INIT window.
    doReset();
    #1;
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd1);
    checkOutput("reset_trigger", {31'd0, bus.acc_trigger}, 32'd0);
    checkOutput("reset_acc_row", {25'd0, bus.acc_row}, 32'd0);
    checkOutput("reset_batch_done", {31'd0, batch_done}, 32'd0);
    checkOutput("reset_err_range", {31'd0, err_range}, 32'd0);
    checkOutput("reset_err_timeout", {31'd0, err_timeout}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    applyStimulus(7'd5, 1'b1, 1'b1, acc);
    checkOutput("t1_accept", {31'd0, acc}, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!batch_done && n < 60);
    if (!batch_done) begin
      total++;
      bad++;
      $display("[TB] FAIL t1_batch_done actual=no pulse required=pulse");
    end else begin
      checkOutput("t1_busy_at_batch_done", {31'd0, busy}, 32'd0);
    end
    checkOutput("t1_first_trigger_cycle", trig_cyc, INIT_DELAY + 1);
    repeat (2) @(negedge clk);

    // Scenario 2: four back-to-back requests, fixed 2-cycle finish.
    fin_lat = 2;
    b0 = batch_cnt;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(7'(10 * (i + 1)), 1'(i), 1'(i >> 1), acc);
      checkOutput("t2_accept", {31'd0, acc}, 32'd1);
    end
    waitIdle("t2", 100);
    checkOutput("t2_batch_count", batch_cnt - b0, 32'd1);

    // Scenario 3: fill the FIFO while the accumulator withholds finish.
    finish_en = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      applyStimulus(7'($urandom_range(0, INPUT_FEATURES - 1)), 1'($urandom), 1'($urandom), acc);
      checkOutput("t3_accept", {31'd0, acc}, 32'd1);
    end
    @(negedge clk);
    checkOutput("t3_level_full", 32'(level), FIFO_DEPTH);
    checkOutput("t3_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    applyStimulus(7'd99, 1'b1, 1'b0, acc);
    checkOutput("t3_reject_when_full", {31'd0, acc}, 32'd0);
    @(negedge clk);
    checkOutput("t3_level_after_reject", 32'(level), FIFO_DEPTH);
    finish_en = 1'b1;
    waitIdle("t3", 400);
    checkOutput("t3_level_drained", 32'(level), 32'd0);

    // Scenario 4: out-of-range row is consumed, flagged and never issued.
    applyStimulus(7'd121, 1'b1, 1'b0, acc);
    checkOutput("t4_accept_121", {31'd0, acc}, 32'd1);
    applyStimulus(7'd127, 1'b0, 1'b1, acc);
    checkOutput("t4_accept_127", {31'd0, acc}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t4_err_range", {31'd0, err_range}, {31'd0, model_err_range});
    checkOutput("t4_level", 32'(level), 32'd0);
    checkOutput("t4_busy", {31'd0, busy}, 32'd0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    model_err_range = 1'b0;
    checkOutput("t4_err_range_cleared", {31'd0, err_range}, 32'd0);

    // Scenario 5: finish never arrives for the first update.
    finish_en = 1'b0;
    applyStimulus(7'd33, 1'b1, 1'b0, acc);
    applyStimulus(7'd44, 1'b0, 1'b1, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_timeout && n < 200);
    if (!err_timeout) begin
      total++;
      bad++;
      $display("[TB] FAIL t5_err_timeout actual=0 required=1");
    end else begin
      checkOutput("t5_timeout_cycles", cyc - trig_cyc, TIMEOUT);
    end
    finish_en = 1'b1;
    waitIdle("t5", 100);
    checkOutput("t5_err_timeout_sticky", {31'd0, err_timeout}, 32'd1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checkOutput("t5_err_timeout_cleared", {31'd0, err_timeout}, 32'd0);

    // Randomised traffic with random finish latency and occasional bad rows.
    rand_lat = 1'b1;
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) != 0)
        applyStimulus(7'($urandom_range(0, 127)), 1'($urandom), 1'($urandom), acc);
      else
        @(negedge clk);
    end
    waitIdle("random", 1000);
    checkOutput("random_err_range", {31'd0, err_range}, {31'd0, model_err_range});
    checkOutput("random_level", 32'(level), 32'd0);
    rand_lat = 1'b0;

    // Scenario 6: reset while an update is in flight with three queued.
    finish_en = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(7'(60 + i), 1'b1, 1'b1, acc);
    @(negedge clk);
    checkOutput("t6_level_before_reset", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_level_in_reset", 32'(level), 32'd0);
    checkOutput("t6_trigger_in_reset", {31'd0, bus.acc_trigger}, 32'd0);
    checkOutput("t6_busy_in_reset", {31'd0, busy}, 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    finish_en = 1'b1;
    applyStimulus(7'd77, 1'b0, 1'b0, acc);
    waitIdle("t6_restart", 100);
    checkOutput("t6_restart_level", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
